// File: rtl/ddr_rd_burst_arbiter.sv
// Round-robin arbiter that shares one DDR read-burst master among NUM_REQ
// RAM loaders. The winner's addr/len are latched at grant time, one burst is
// run, and valid/finish are routed back to the granted requester only.
//
// Handshake: a requester raises req_i[i] and holds it until it sees
// req_finish_o[i]. The arbiter holds m_rd_burst_req until m_rd_burst_finish.
// Beats are qualified by m_rd_burst_valid and are routed only while in BURST.
module ddr_rd_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len_i,
  output logic [NUM_REQ-1:0]             req_valid_o,
  output logic [NUM_REQ-1:0]             req_finish_o,
  output logic [DATA_WIDTH-1:0]          req_data_o,
  output logic                           m_rd_burst_req,
  output logic [ADDR_SIZE-1:0]           m_rd_burst_addr,
  output logic [LEN_WIDTH-1:0]           m_rd_burst_len,
  input  logic [DATA_WIDTH-1:0]          m_rd_burst_data,
  input  logic                           m_rd_burst_valid,
  input  logic                           m_rd_burst_finish,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o,
  output logic [1:0]                     state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BURST   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] g_idx;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic             in_burst;
  logic             zero_len_pulse;

  // Round-robin pick: first pending request scanning upward from rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_i[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // State register.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a zero-length grant skips the DDR request entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (win_found) state_nxt = S_GRANT;
      S_GRANT:   state_nxt = (m_rd_burst_len == '0) ? S_RELEASE : S_BURST;
      S_BURST:   if (m_rd_burst_finish) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Grant, latched burst parameters, DDR request and round-robin pointer.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      rr_ptr          <= '0;
      g_idx           <= '0;
      grant_o         <= '0;
      m_rd_burst_req  <= 1'b0;
      m_rd_burst_addr <= '0;
      m_rd_burst_len  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_o         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            g_idx           <= win_idx;
            m_rd_burst_addr <= req_addr_i[win_idx*ADDR_SIZE +: ADDR_SIZE];
            m_rd_burst_len  <= req_len_i[win_idx*LEN_WIDTH +: LEN_WIDTH];
          end
        end
        S_GRANT: begin
          if (m_rd_burst_len != '0) m_rd_burst_req <= 1'b1;
        end
        S_BURST: begin
          if (m_rd_burst_finish) m_rd_burst_req <= 1'b0;
        end
        S_RELEASE: begin
          // The requester after the one just served gets first look next time.
          rr_ptr  <= (g_idx == PTR_W'(NUM_REQ-1)) ? '0 : g_idx + PTR_W'(1);
          grant_o <= '0;
        end
        default: ;
      endcase
    end
  end

  // Routing: beats and finish reach the granted requester only during BURST,
  // so stray master strobes in any other state are dropped.
  assign in_burst       = (state == S_BURST);
  assign zero_len_pulse = (state == S_GRANT) && (m_rd_burst_len == '0);
  assign req_valid_o    = {NUM_REQ{m_rd_burst_valid & in_burst}} & grant_o;
  assign req_finish_o   = {NUM_REQ{(m_rd_burst_finish & in_burst) | zero_len_pulse}} & grant_o;
  assign req_data_o     = m_rd_burst_data;
  assign busy_o         = (state != S_IDLE);
  assign state_o        = state;

endmodule

// File: tb/tb_ddr_rd_burst_arbiter.sv
// Directed bench for ddr_rd_burst_arbiter. Stimulus tasks push expected
// grant/beat/finish events into exp_q; a negedge monitor pops and compares
// whenever the DUT presents one.
module tb_ddr_rd_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 10;
  localparam int W  = 48;   // {kind[1:0], onehot[3:0], payload[41:0]}

  // ---------------- clock / reset ----------------
  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  always #5 s_clk = ~s_clk;

  logic [N-1:0]    req_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*LW-1:0] req_len_i = '0;
  logic [N-1:0]    req_valid_o, req_finish_o, grant_o;
  logic [DW-1:0]   req_data_o;
  logic            m_rd_burst_req;
  logic [AW-1:0]   m_rd_burst_addr;
  logic [LW-1:0]   m_rd_burst_len;
  logic [DW-1:0]   m_rd_burst_data = '0;
  logic            m_rd_burst_valid = 1'b0;
  logic            m_rd_burst_finish = 1'b0;
  logic            busy_o;
  logic [1:0]      state_o;

  ddr_rd_burst_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_SIZE(AW), .LEN_WIDTH(LW)) dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_valid_o(req_valid_o), .req_finish_o(req_finish_o), .req_data_o(req_data_o),
    .m_rd_burst_req(m_rd_burst_req), .m_rd_burst_addr(m_rd_burst_addr),
    .m_rd_burst_len(m_rd_burst_len), .m_rd_burst_data(m_rd_burst_data),
    .m_rd_burst_valid(m_rd_burst_valid), .m_rd_burst_finish(m_rd_burst_finish),
    .grant_o(grant_o), .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic prev_mreq = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input logic [W-1:0] obs);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got %0h expected nothing", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h", name, obs, e);
      end
    end
  endtask

  // Monitor: new DDR request, routed beat, routed finish.
  always @(negedge s_clk) begin
    if (s_rst) begin
      prev_mreq = 1'b0;
    end else begin
      if (m_rd_burst_req && !prev_mreq)
        score("grant", {2'd0, grant_o, m_rd_burst_addr, m_rd_burst_len});
      if (req_valid_o != '0)
        score("beat", {2'd1, req_valid_o, req_data_o[41:0]});
      if (req_finish_o != '0)
        score("finish", {2'd2, req_finish_o, 42'd0});
      prev_mreq = m_rd_burst_req;
    end
  end

  // ---------------- expectation helpers ----------------
  task automatic exp_grant(input int idx, input logic [31:0] addr, input logic [9:0] len);
    exp_q.push_back({2'd0, 4'(1 << idx), addr, len});
  endtask

  task automatic exp_beats(input int idx, input int n, input int tag);
    for (int b = 0; b < n; b++) exp_q.push_back({2'd1, 4'(1 << idx), 42'(tag * 256 + b)});
  endtask

  task automatic exp_finish(input int idx);
    exp_q.push_back({2'd2, 4'(1 << idx), 42'd0});
  endtask

  task automatic exp_burst(input int idx, input logic [31:0] addr, input logic [9:0] len, input int tag);
    exp_grant(idx, addr, len);
    exp_beats(idx, int'(len), tag);
    exp_finish(idx);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr, input logic [9:0] len);
    req_addr_i[idx*AW +: AW] = addr;
    req_len_i[idx*LW +: LW]  = len;
    req_i[idx]               = 1'b1;
  endtask

  task automatic wait_mreq();
    bit ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_rd_burst_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_mreq: got timeout expected m_rd_burst_req");
    end
  endtask

  // DDR master model: n beats, then a one-cycle finish. The requester drops
  // req after finish when drop=1, or before beat drop_mid when drop_mid>=0.
  task automatic drive_beats(input int idx, input int n, input int tag, input bit drop, input int drop_mid);
    for (int b = 0; b < n; b++) begin
      if (b == drop_mid) req_i[idx] = 1'b0;
      m_rd_burst_valid = 1'b1;
      m_rd_burst_data  = 64'(tag * 256 + b);
      step();
    end
    m_rd_burst_valid  = 1'b0;
    m_rd_burst_finish = 1'b1;
    step();
    m_rd_burst_finish = 1'b0;
    if (drop) req_i[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;

    // Reset state
    @(negedge s_clk);
    check("rst_grant", grant_o, 0);
    check("rst_mreq", m_rd_burst_req, 0);
    check("rst_maddr", m_rd_burst_addr, 0);
    check("rst_mlen", m_rd_burst_len, 0);
    check("rst_busy", busy_o, 0);
    check("rst_state", state_o, 0);
    step();
    s_rst = 1'b0;
    step();

    // 1: single req0, latency 2 edges, 8 beats to req0 only
    exp_burst(0, 32'h1000, 10'd8, 1);
    set_req(0, 32'h1000, 10'd8);
    step();
    check("t1_mreq_edge1", m_rd_burst_req, 0);
    step();
    check("t1_mreq_edge2", m_rd_burst_req, 1);
    drive_beats(0, 8, 1, 1'b1, -1);
    step();
    check("t1_grant_idle", grant_o, 0);
    check("t1_busy_idle", busy_o, 0);

    // 4: req3 zero length -> finish pulse, no DDR request (rr_ptr 1 -> 0)
    exp_finish(3);
    set_req(3, 32'h3000, 10'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (m_rd_burst_req) seen = 1'b1;
      if (c == 1) req_i[3] = 1'b0;
    end
    check("t4_no_mreq", seen, 0);
    check("t4_grant_idle", grant_o, 0);

    // 2: all four at once from rr_ptr=0 -> 0,1,2,3; then req0 again -> 0
    for (int i = 0; i < N; i++) exp_burst(i, 32'h2000 + 32'(i * 256), 10'd2, 16 + i);
    for (int i = 0; i < N; i++) set_req(i, 32'h2000 + 32'(i * 256), 10'd2);
    for (int i = 0; i < N; i++) begin
      wait_mreq();
      drive_beats(i, 2, 16 + i, 1'b1, -1);
    end
    step();
    exp_burst(0, 32'h2400, 10'd3, 32);
    set_req(0, 32'h2400, 10'd3);
    wait_mreq();
    drive_beats(0, 3, 32, 1'b1, -1);
    step();

    // 3: req1 held, req2 raised during req1 burst -> 2 before 1 again
    exp_burst(1, 32'h5000, 10'd3, 48);
    exp_burst(2, 32'h6000, 10'd2, 49);
    exp_burst(1, 32'h5000, 10'd3, 50);
    set_req(1, 32'h5000, 10'd3);
    wait_mreq();
    set_req(2, 32'h6000, 10'd2);
    drive_beats(1, 3, 48, 1'b0, -1);
    wait_mreq();
    drive_beats(2, 2, 49, 1'b1, -1);
    wait_mreq();
    drive_beats(1, 3, 50, 1'b1, -1);
    step();

    // 5: bump rr_ptr to 1, then reset during beat 3 of req2's burst
    exp_burst(0, 32'h8000, 10'd1, 64);
    set_req(0, 32'h8000, 10'd1);
    wait_mreq();
    drive_beats(0, 1, 64, 1'b1, -1);
    exp_grant(2, 32'h9000, 10'd8);
    exp_beats(2, 3, 65);
    set_req(2, 32'h9000, 10'd8);
    wait_mreq();
    for (int b = 0; b < 3; b++) begin
      m_rd_burst_valid = 1'b1;
      m_rd_burst_data  = 64'(65 * 256 + b);
      step();
    end
    m_rd_burst_data = 64'(65 * 256 + 3);
    s_rst = 1'b1;
    #2;
    check("t5_grant", grant_o, 0);
    check("t5_valid", req_valid_o, 0);
    check("t5_finish", req_finish_o, 0);
    check("t5_mreq", m_rd_burst_req, 0);
    check("t5_maddr", m_rd_burst_addr, 0);
    check("t5_mlen", m_rd_burst_len, 0);
    check("t5_busy", busy_o, 0);
    check("t5_queue_empty", exp_q.size(), 0);
    req_i = '0;
    m_rd_burst_valid = 1'b0;
    step();
    s_rst = 1'b0;
    step();
    exp_burst(0, 32'hA000, 10'd2, 66);
    exp_burst(3, 32'hB000, 10'd2, 67);
    set_req(0, 32'hA000, 10'd2);
    set_req(3, 32'hB000, 10'd2);
    wait_mreq();
    drive_beats(0, 2, 66, 1'b1, -1);
    wait_mreq();
    drive_beats(3, 2, 67, 1'b1, -1);
    step();

    // 6: late addr/len change ignored, req0 drops mid-burst, spurious strobes in IDLE
    exp_burst(0, 32'h7000, 10'd4, 80);
    set_req(0, 32'h7000, 10'd4);
    wait_mreq();
    req_addr_i[0 +: AW] = 32'hDEAD_BEEF;
    req_len_i[0 +: LW]  = 10'd5;
    step();
    check("t6_addr_stable", m_rd_burst_addr, 32'h7000);
    check("t6_len_stable", m_rd_burst_len, 4);
    drive_beats(0, 4, 80, 1'b1, 2);
    step();
    m_rd_burst_valid  = 1'b1;
    m_rd_burst_finish = 1'b1;
    m_rd_burst_data   = 64'h55;
    #2;
    check("t6_idle_valid", req_valid_o, 0);
    check("t6_idle_finish", req_finish_o, 0);
    step();
    m_rd_burst_valid  = 1'b0;
    m_rd_burst_finish = 1'b0;
    check("t6_idle_busy", busy_o, 0);
    check("t6_idle_state", state_o, 0);

    repeat (3) step();
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
